// File: rtl/seq_addsub.sv
// seq_addsub: multi-cycle add/subtract unit that sums one CHUNK-bit slice per
// cycle, LSB slice first, with a registered carry chained between slices.
// Operations: 00 ADD, 01 SUB, 10 ADC, 11 SBB. Flags are {C,V,Z,N}.
// Optional feature: define SEQ_ADDSUB_SAT_EN to build signed saturation of rd
// when the captured sat bit is set and the result overflows; otherwise the sat
// port is accepted and ignored.
module seq_addsub #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic             cin,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rd,
  output logic [3:0]       flags
);

  localparam int unsigned NSLICE = WIDTH / CHUNK;
  localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               a_sign_q, a_sign_d;
  logic               b_sign_q, b_sign_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   rd_q, rd_d;
  logic [3:0]         flags_q, flags_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;
`ifdef SEQ_ADDSUB_SAT_EN
  logic               sat_q, sat_d;
`else
  logic               unused_sat;
  assign unused_sat = sat;
`endif

  logic [CHUNK:0]     sum_w;
  logic [WIDTH-1:0]   res_next;
  logic [WIDTH-1:0]   final_rd;
  logic [WIDTH-1:0]   b_eff;
  logic               final_v;

  // Slice adder and final result/overflow evaluation
  always_comb begin
    sum_w    = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + (CHUNK+1)'(carry_q);
    res_next = (res_q >> CHUNK) | (WIDTH'(sum_w[CHUNK-1:0]) << (WIDTH - CHUNK));
    final_v  = (a_sign_q == b_sign_q) && (res_next[WIDTH-1] != a_sign_q);
    final_rd = res_next;
`ifdef SEQ_ADDSUB_SAT_EN
    // Positive overflow shows a negative raw sign, so clamp to max positive
    if (sat_q && final_v) begin
      final_rd = {~res_next[WIDTH-1], {(WIDTH-1){res_next[WIDTH-1]}}};
    end
`endif
    b_eff = op[0] ? ~rs2 : rs2;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    a_sign_d    = a_sign_q;
    b_sign_d    = b_sign_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    res_d       = res_q;
    rd_d        = rd_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
`ifdef SEQ_ADDSUB_SAT_EN
    sat_d       = sat_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d        = rs1;
          b_d        = b_eff;
          a_sign_d   = rs1[WIDTH-1];
          b_sign_d   = b_eff[WIDTH-1];
          // ADD:0, SUB:1, ADC/SBB: cin
          carry_d    = op[1] ? cin : op[0];
          cnt_d      = '0;
          res_d      = '0;
          state_d    = CALC;
          in_ready_d = 1'b0;
`ifdef SEQ_ADDSUB_SAT_EN
          sat_d      = sat;
`endif
        end
      end

      CALC: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = sum_w[CHUNK];
        res_d   = res_next;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NSLICE - 1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          rd_d        = final_rd;
          flags_d     = {sum_w[CHUNK], final_v, (final_rd == '0), final_rd[WIDTH-1]};
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // State register with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      a_sign_q    <= 1'b0;
      b_sign_q    <= 1'b0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      res_q       <= '0;
      rd_q        <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef SEQ_ADDSUB_SAT_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      a_sign_q    <= a_sign_d;
      b_sign_q    <= b_sign_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      rd_q        <= rd_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
`ifdef SEQ_ADDSUB_SAT_EN
      sat_q       <= sat_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign rd        = rd_q;
  assign flags     = flags_q;

endmodule

// File: doc/seq_addsub.md
SEQ_ADDSUB -- requirements
Module: seq_addsub

Interface
REQ-001 Parameter WIDTH, default 16: operand/result width; SHALL be a multiple of CHUNK and at least 8.
REQ-002 Parameter CHUNK, default 4: bits summed per cycle; SHALL divide WIDTH.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  operands and op presented.
REQ-007 in_ready  output  1  block can accept an operation.
REQ-008 op  input  2  00 ADD, 01 SUB, 10 ADC, 11 SBB.
REQ-009 rs1, rs2  input  WIDTH  operands, unsigned or two's-complement.
REQ-010 cin  input  1  carry-in, used by ADC and SBB only.
REQ-011 sat  input  1  signed-saturate request; see REQ-030.
REQ-012 out_valid  output  1  result and flags valid.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 rd  output  WIDTH  result.
REQ-015 flags  output  4  {C,V,Z,N}: carry-out, signed overflow, zero, negative.

Function
REQ-016 FSM states: IDLE, CALC, DONE; in_ready SHALL be 1 only in IDLE.
REQ-017 Handshake: in_valid&&in_ready in IDLE SHALL capture rs1, rs2, op, cin and sat, and move to CALC; later input changes SHALL have no effect.
REQ-018 Effective second operand: ADD/ADC use rs2; SUB/SBB use ~rs2.
REQ-019 Initial carry: ADD 0, SUB 1, ADC cin, SBB cin (cin=1 means no borrow).
REQ-020 CALC SHALL add one CHUNK-bit slice per cycle, LSB slice first, chaining carry through a registered carry bit.
REQ-021 After WIDTH/CHUNK CALC cycles the FSM SHALL enter DONE with out_valid=1; capture-to-out_valid latency is exactly WIDTH/CHUNK cycles (4 at defaults).
REQ-022 C SHALL be the carry out of bit WIDTH-1; for SUB/SBB, C=1 means no borrow.
REQ-023 V SHALL be 1 when the operand sign bits (after REQ-018) are equal and differ from the result sign bit.
REQ-024 Z SHALL be 1 when rd==0, and N SHALL equal rd[WIDTH-1]; both SHALL be evaluated on the final, possibly saturated, rd.
REQ-025 rd and flags SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 out_valid&&out_ready SHALL return the FSM to IDLE next cycle; out_valid SHALL drop and in_ready SHALL rise in that cycle.
REQ-027 No input SHALL be accepted in the DONE-to-IDLE transfer cycle; peak throughput is one op per WIDTH/CHUNK+2 cycles.
REQ-028 Undefined op encodings do not exist; all four SHALL be decoded.

Reset
REQ-029 rst_n low, at any time including mid-CALC, SHALL immediately force IDLE, in_ready=1, out_valid=0, rd=0, flags=0, and clear the internal carry and slice counter; the in-flight operation SHALL be discarded.

Configuration
REQ-030 Macro SEQ_ADDSUB_SAT_EN defined: when captured sat=1 and V=1, rd SHALL clamp to 0x7FFF.. (result sign 1) or 0x8000.. (result sign 0); V SHALL still read 1; C SHALL be unclamped.
REQ-031 Macro SEQ_ADDSUB_SAT_EN undefined: the sat port SHALL exist but be ignored, and no clamp logic SHALL be built.

Verification (WIDTH=16, CHUNK=4)
REQ-032 ADD 0xFFFF+0x0001 -> rd=0x0000, C=1, V=0, Z=1, N=0, out_valid exactly 4 cycles after capture.
REQ-033 ADD 0x7FFF+0x0001, sat=1 -> with macro: rd=0x7FFF, V=1, N=0; without macro: rd=0x8000, V=1, N=1.
REQ-034 SUB 0x0005-0x0007 -> rd=0xFFFE, C=0, N=1, V=0; SBB 0x0005,0x0003, cin=0 -> rd=0x0001, C=1.
REQ-035 Hold out_ready=0 for 10 cycles in DONE -> rd and flags stable, in_ready=0, and in_valid ignored.
REQ-036 Assert rst_n low 2 cycles after capture -> outputs zero, in_ready=1, and the next op completes correctly with no stale carry.
